code_conv_pipe: RTL and testbench

CODE_CONV_PIPE -- requirements
Module: code_conv_pipe

---
 rtl/code_conv_pipe.sv | 92 +++++++++
 tb/tb_code_conv_pipe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/code_conv_pipe.sv
// Two-stage valid/ready pipeline converting between binary and Gray code.
// S1 registers the operand, S2 registers the converted result.
module code_conv_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_mode
);

  localparam logic [1:0] MODE_B2G  = 2'b00;
  localparam logic [1:0] MODE_G2B  = 2'b01;
  localparam logic [1:0] MODE_PASS = 2'b10;

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [1:0]       s1_mode;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_data;
  logic [1:0]       s2_mode;
  logic             s1_load;
  logic             s2_load;
  logic [WIDTH-1:0] result;

  // S2 takes whatever S1 holds (possibly a bubble) whenever it can drain.
  assign s2_load  = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = rst_n && s1_load;

  always_comb begin
    result = s1_data;
    case (s1_mode)
      MODE_B2G:  result = bin2gray(s1_data);
      MODE_G2B:  result = gray2bin(s1_data);
      MODE_PASS: result = s1_data;
      default:   result = bin2gray(gray2bin(s1_data) + {{(WIDTH-1){1'b0}}, 1'b1});
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= 2'b00;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_mode <= in_mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_mode  <= 2'b00;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= result;
        s2_mode <= s1_mode;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_mode  = s2_mode;

endmodule

// File: tb/tb_code_conv_pipe.sv
// Directed bench for code_conv_pipe: 4-bit instance for handshake/conversion
// scenarios, 8-bit instance for the full Gray increment cycle.
module tb_code_conv_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [3:0] in_data, out_data;
  logic [1:0] in_mode, out_mode;
  logic       in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0] in_data8, out_data8;
  logic [1:0] in_mode8, out_mode8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  code_conv_pipe #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
  );

  code_conv_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_mode(in_mode8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8), .out_mode(out_mode8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; in_data8 = '0; in_mode8 = '0; out_ready8 = 1'b1;
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 4'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_cmp++; if (out_mode !== 2'b00) begin n_err++; $display("FAIL reset_out_mode: got %b want 00", out_mode); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 4'hB; in_mode = 2'b00;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid: got %b want 0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 4'hE) begin n_err++; $display("FAIL single_data: got %h want e", out_data); end
    n_cmp++; if (out_mode !== 2'b00) begin n_err++; $display("FAIL single_mode: got %b want 00", out_mode); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_trailing_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] din [5] = '{4'hE, 4'h8, 4'h7, 4'h3, 4'hF};
    logic [1:0] md  [5] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b11};
    logic [3:0] exp [5] = '{4'hB, 4'h0, 4'h4, 4'h3, 4'hE};
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c < 5) begin
        in_valid = 1'b1; in_data = din[c]; in_mode = md[c];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 2) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want 1", c - 2, out_valid); end
        n_cmp++; if (out_data !== exp[c-2]) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", c - 2, out_data, exp[c-2]); end
        n_cmp++; if (out_mode !== md[c-2]) begin n_err++; $display("FAIL b2b_mode[%0d]: got %b want %b", c - 2, out_mode, md[c-2]); end
      end
      tick();
    end
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'h1; in_mode = 2'b10;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready0: got %b want 1", in_ready); end
    tick();
    in_data = 4'h2;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready1: got %b want 1", in_ready); end
    tick();
    in_data = 4'h3;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_full_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_data !== 4'h1) begin n_err++; $display("FAIL fill_head: got %h want 1", out_data); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 4'h1) begin n_err++; $display("FAIL fill_hold: got valid %b data %h want 1/1", out_valid, out_data); end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_dual_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 4'h2) begin n_err++; $display("FAIL fill_second: got valid %b data %h want 1/2", out_valid, out_data); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 4'h3 || out_mode !== 2'b10) begin n_err++; $display("FAIL fill_third: got %b/%h/%b want 1/3/10", out_valid, out_data, out_mode); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fill_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    int seen = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'h5; in_mode = 2'b10;
    #1;
    tick();
    in_data = 4'h6;
    #1;
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 4'h5) begin n_err++; $display("FAIL midrst_pre: got %b/%h want 1/5", out_valid, out_data); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 4'h0) begin n_err++; $display("FAIL midrst_data: got %h want 0", out_data); end
    n_cmp++; if (out_mode !== 2'b00) begin n_err++; $display("FAIL midrst_mode: got %b want 00", out_mode); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
    tick(); tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_release_ready: got %b want 1", in_ready); end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (out_valid !== 1'b0) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL midrst_stale: got %0d stale beats want 0", seen); end
  endtask

  task automatic test_stream();
    logic [3:0] exp [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                             4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    int sent = 0;
    int rcv = 0;
    logic stalled = 1'b0;
    logic [3:0] held = '0;
    for (int cyc = 0; cyc < 300 && rcv < 16; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid = (sent < 16);
      in_data = sent[3:0];
      in_mode = 2'b00;
      #1;
      if (stalled) begin
        n_cmp++; if (out_valid !== 1'b1 || out_data !== held) begin n_err++; $display("FAIL stream_stall: got %b/%h want 1/%h", out_valid, out_data, held); end
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_cmp++; if (out_data !== exp[rcv] || out_mode !== 2'b00) begin n_err++; $display("FAIL stream_beat[%0d]: got %h/%b want %h/00", rcv, out_data, out_mode, exp[rcv]); end
        rcv++;
      end
      stalled = (out_valid === 1'b1) && !out_ready;
      held = out_data;
      if (in_valid && in_ready === 1'b1) sent++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_cmp++; if (rcv != 16) begin n_err++; $display("FAIL stream_count: got %0d want 16", rcv); end
  endtask

  task automatic test_w8_increment();
    logic [7:0] cur = 8'h00;
    int w;
    out_ready8 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_valid8 = 1'b1; in_data8 = cur; in_mode8 = 2'b11;
      #1;
      tick();
      in_valid8 = 1'b0;
      w = 0;
      while (out_valid8 !== 1'b1 && w < 8) begin
        tick();
        w++;
      end
      n_cmp++;
      if (out_valid8 !== 1'b1) begin
        n_err++; $display("FAIL w8_timeout[%0d]: got no result want out_valid", i);
      end else if ($countones(out_data8 ^ cur) != 1) begin
        n_err++; $display("FAIL w8_onebit[%0d]: got %h from %h want one-bit change", i, out_data8, cur);
      end
      if (i < 255) begin
        n_cmp++; if (out_data8 === 8'h00) begin n_err++; $display("FAIL w8_early_wrap[%0d]: got 00 want nonzero", i); end
      end else begin
        n_cmp++; if (out_data8 !== 8'h00) begin n_err++; $display("FAIL w8_wrap: got %h want 00", out_data8); end
      end
      cur = out_data8;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_reset_midstream();
    test_stream();
    test_w8_increment();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
